// File: rtl/pipeline_id_hazard.sv
// ID stage: register file, EX/MEM forwarding, load-use stall, branch resolution, ID/EX register.
// Optional macro REGFILE_BYPASS_EN: WB write-through bypass instead of a one-cycle WB stall.
module pipeline_id_hazard #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int CTRL_W = 20,
    parameter int CNT_W  = 16,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [AW-1:0]     id_rs,
    input  logic [AW-1:0]     id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [15:0]       id_imm16,
    input  logic [XLEN-1:0]   id_ext_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [2:0]        id_br_type,
    input  logic [AW-1:0]     id_wr_reg,
    input  logic              ex_valid,
    input  logic              ex_regwr,
    input  logic              ex_memrd,
    input  logic [AW-1:0]     ex_wr_reg,
    input  logic [XLEN-1:0]   ex_result,
    input  logic              mem_valid,
    input  logic              mem_regwr,
    input  logic [AW-1:0]     mem_wr_reg,
    input  logic [XLEN-1:0]   mem_result,
    input  logic              wb_regwr,
    input  logic [AW-1:0]     wb_wr_reg,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_flush,
    output logic              stall_out,
    output logic              br_taken,
    output logic [XLEN-1:0]   br_target,
    output logic              idex_valid,
    output logic [XLEN-1:0]   idex_pc,
    output logic [CTRL_W-1:0] idex_ctrl,
    output logic [XLEN-1:0]   idex_busa,
    output logic [XLEN-1:0]   idex_busb,
    output logic [XLEN-1:0]   idex_imm,
    output logic [AW-1:0]     idex_wr_reg,
    output logic [CNT_W-1:0]  stall_count
);

    logic [XLEN-1:0]   rf_q [NREG];
    logic [XLEN-1:0]   op_a, op_b;
    logic              ex_fwd_ok, mem_fwd_ok, wb_wr_ok;
    logic              load_use, wb_haz, hazard, cond, bubble;
    logic              idex_valid_q;
    logic [XLEN-1:0]   idex_pc_q, idex_busa_q, idex_busb_q, idex_imm_q;
    logic [CTRL_W-1:0] idex_ctrl_q;
    logic [AW-1:0]     idex_wr_reg_q;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    assign ex_fwd_ok  = ex_valid & ex_regwr & ~ex_memrd;
    assign mem_fwd_ok = mem_valid & mem_regwr;
    assign wb_wr_ok   = wb_regwr & (wb_wr_reg != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wb_wr_ok) begin
            rf_q[wb_wr_reg] <= wb_data;
        end
    end

    // Operand select: register 0 is hard zero and never forwarded.
    always_comb begin
        op_a = rf_q[id_rs];
        if (id_rs == '0)                              op_a = '0;
        else if (ex_fwd_ok && ex_wr_reg == id_rs)     op_a = ex_result;
        else if (mem_fwd_ok && mem_wr_reg == id_rs)   op_a = mem_result;
`ifdef REGFILE_BYPASS_EN
        else if (wb_wr_ok && wb_wr_reg == id_rs)      op_a = wb_data;
`endif
    end

    always_comb begin
        op_b = rf_q[id_rt];
        if (id_rt == '0)                              op_b = '0;
        else if (ex_fwd_ok && ex_wr_reg == id_rt)     op_b = ex_result;
        else if (mem_fwd_ok && mem_wr_reg == id_rt)   op_b = mem_result;
`ifdef REGFILE_BYPASS_EN
        else if (wb_wr_ok && wb_wr_reg == id_rt)      op_b = wb_data;
`endif
    end

    assign load_use = ex_valid & ex_memrd & ex_regwr & (ex_wr_reg != '0) &
                      ((id_use_rs & (id_rs == ex_wr_reg)) | (id_use_rt & (id_rt == ex_wr_reg)));

`ifdef REGFILE_BYPASS_EN
    assign wb_haz = 1'b0;
`else
    // Without bypass, the reader waits one cycle so the register file holds the new value.
    assign wb_haz = wb_wr_ok &
                    ((id_use_rs & (id_rs == wb_wr_reg)) | (id_use_rt & (id_rt == wb_wr_reg)));
`endif

    assign hazard    = load_use | wb_haz;
    assign stall_out = id_valid & hazard & ~ex_flush;

    always_comb begin
        cond = 1'b0;
        case (id_br_type)
            3'd1:    cond = $signed(op_a) < 0;
            3'd2:    cond = (op_a == op_b);
            3'd3:    cond = (op_a != op_b);
            3'd4:    cond = $signed(op_a) <= 0;
            3'd5:    cond = $signed(op_a) > 0;
            3'd6:    cond = $signed(op_a) >= 0;
            default: cond = 1'b0;
        endcase
    end

    assign br_taken  = id_valid & cond & ~stall_out & ~ex_flush;
    assign br_target = id_pc + XLEN'(4) + {{(XLEN-18){id_imm16[15]}}, id_imm16, 2'b00};

    assign bubble        = ex_flush | stall_out | ~id_valid;
    assign stall_count_d = (stall_out && stall_count_q != '1) ? stall_count_q + 1'b1 : stall_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex_valid_q  <= 1'b0;
            idex_pc_q     <= '0;
            idex_ctrl_q   <= '0;
            idex_busa_q   <= '0;
            idex_busb_q   <= '0;
            idex_imm_q    <= '0;
            idex_wr_reg_q <= '0;
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            if (bubble) begin
                idex_valid_q  <= 1'b0;
                idex_pc_q     <= '0;
                idex_ctrl_q   <= '0;
                idex_busa_q   <= '0;
                idex_busb_q   <= '0;
                idex_imm_q    <= '0;
                idex_wr_reg_q <= '0;
            end else begin
                idex_valid_q  <= 1'b1;
                idex_pc_q     <= id_pc;
                idex_ctrl_q   <= id_ctrl;
                idex_busa_q   <= op_a;
                idex_busb_q   <= op_b;
                idex_imm_q    <= id_ext_imm;
                idex_wr_reg_q <= id_wr_reg;
            end
        end
    end

    assign idex_valid  = idex_valid_q;
    assign idex_pc     = idex_pc_q;
    assign idex_ctrl   = idex_ctrl_q;
    assign idex_busa   = idex_busa_q;
    assign idex_busb   = idex_busb_q;
    assign idex_imm    = idex_imm_q;
    assign idex_wr_reg = idex_wr_reg_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_id_hazard.sv
// Directed bench for pipeline_id_hazard: expected ID/EX contents are queued at drive time and popped after each edge.
module tb_pipeline_id_hazard;

    localparam int XLEN = 32, NREG = 32, CTRL_W = 20, CNT_W = 3, AW = 5;

    logic              clk, reset;
    logic              id_valid, id_use_rs, id_use_rt;
    logic [XLEN-1:0]   id_pc, id_ext_imm;
    logic [AW-1:0]     id_rs, id_rt, id_wr_reg;
    logic [15:0]       id_imm16;
    logic [CTRL_W-1:0] id_ctrl;
    logic [2:0]        id_br_type;
    logic              ex_valid, ex_regwr, ex_memrd;
    logic [AW-1:0]     ex_wr_reg;
    logic [XLEN-1:0]   ex_result;
    logic              mem_valid, mem_regwr;
    logic [AW-1:0]     mem_wr_reg;
    logic [XLEN-1:0]   mem_result;
    logic              wb_regwr;
    logic [AW-1:0]     wb_wr_reg;
    logic [XLEN-1:0]   wb_data;
    logic              ex_flush;
    logic              stall_out, br_taken;
    logic [XLEN-1:0]   br_target;
    logic              idex_valid;
    logic [XLEN-1:0]   idex_pc, idex_busa, idex_busb, idex_imm;
    logic [CTRL_W-1:0] idex_ctrl;
    logic [AW-1:0]     idex_wr_reg;
    logic [CNT_W-1:0]  stall_count;

    typedef struct packed {
        logic              v;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [XLEN-1:0]   pc;
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   imm;
        logic [AW-1:0]     wr;
    } idex_t;

    idex_t            exp_q[$];
    int               n_vec = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    pipeline_id_hazard #(.XLEN(XLEN), .NREG(NREG), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_imm16(id_imm16),
        .id_ext_imm(id_ext_imm), .id_ctrl(id_ctrl), .id_br_type(id_br_type),
        .id_wr_reg(id_wr_reg),
        .ex_valid(ex_valid), .ex_regwr(ex_regwr), .ex_memrd(ex_memrd),
        .ex_wr_reg(ex_wr_reg), .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_regwr(mem_regwr), .mem_wr_reg(mem_wr_reg),
        .mem_result(mem_result),
        .wb_regwr(wb_regwr), .wb_wr_reg(wb_wr_reg), .wb_data(wb_data),
        .ex_flush(ex_flush),
        .stall_out(stall_out), .br_taken(br_taken), .br_target(br_target),
        .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_ctrl(idex_ctrl),
        .idex_busa(idex_busa), .idex_busb(idex_busb), .idex_imm(idex_imm),
        .idex_wr_reg(idex_wr_reg), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_rs = 0; id_rt = 0;
        id_pc = 0; id_imm16 = 0; id_br_type = 0;
        id_ext_imm = XLEN'($urandom_range(1, 32'hFFFF));
        id_ctrl    = CTRL_W'($urandom_range(1, 32'hFFFFF));
        id_wr_reg  = AW'($urandom_range(1, 31));
        ex_valid = 0; ex_regwr = 0; ex_memrd = 0; ex_wr_reg = 0; ex_result = 0;
        mem_valid = 0; mem_regwr = 0; mem_wr_reg = 0; mem_result = 0;
        wb_regwr = 0; wb_wr_reg = 0; wb_data = 0; ex_flush = 0;
    endtask

    // Expected ID/EX content for the instruction currently driven.
    function automatic idex_t mk(input logic v, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        idex_t e;
        e = '0;
        if (v) begin
            e.v = 1'b1; e.a = a; e.b = b; e.pc = id_pc;
            e.ctrl = id_ctrl; e.imm = id_ext_imm; e.wr = id_wr_reg;
        end
        return e;
    endfunction

    // Checks stall_out before the edge, then pops and compares the registered result.
    task automatic tick(input logic exp_stall);
        idex_t e;
        #1;
        chk("stall_out", XLEN'(stall_out), XLEN'(exp_stall));
        @(posedge clk);
        if (exp_stall && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        #1;
        if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = exp_q.pop_front();
            chk("idex_valid",  XLEN'(idex_valid),  XLEN'(e.v));
            chk("idex_busa",   idex_busa,          e.a);
            chk("idex_busb",   idex_busb,          e.b);
            chk("idex_pc",     idex_pc,            e.pc);
            chk("idex_ctrl",   XLEN'(idex_ctrl),   XLEN'(e.ctrl));
            chk("idex_imm",    idex_imm,           e.imm);
            chk("idex_wr_reg", XLEN'(idex_wr_reg), XLEN'(e.wr));
        end
        chk("stall_count", XLEN'(stall_count), XLEN'(exp_cnt));
    endtask

    task automatic wb_write(input logic [AW-1:0] r, input logic [XLEN-1:0] d);
        idle();
        wb_regwr = 1; wb_wr_reg = r; wb_data = d;
        exp_q.push_back(mk(0, 0, 0));
        tick(0);
        idle();
    endtask

    task automatic br_chk(input string tag, input logic [2:0] t, input logic exp);
        id_br_type = t;
        #1;
        chk(tag, XLEN'(br_taken), XLEN'(exp));
    endtask

    initial begin
        idle();
        reset = 0;
        #1;
        chk("rst_idex_valid",  XLEN'(idex_valid),  0);
        chk("rst_idex_busa",   idex_busa,          0);
        chk("rst_stall_count", XLEN'(stall_count), 0);
        @(posedge clk); #1;
        reset = 1;

        wb_write(1, 7);
        wb_write(2, 7);
        wb_write(4, 32'hFFFF_FFFF);
        wb_write(5, 32'h55);

        // EX forwarding beats MEM; rt comes from the register file.
        idle();
        id_valid = 1; id_rs = 5; id_rt = 1; id_use_rs = 1; id_use_rt = 1; id_pc = 32'h40;
        ex_valid = 1; ex_regwr = 1; ex_wr_reg = 5; ex_result = 32'h1234;
        mem_valid = 1; mem_regwr = 1; mem_wr_reg = 5; mem_result = 32'h9999;
        exp_q.push_back(mk(1, 32'h1234, 7));
        tick(0);

        ex_valid = 0;
        exp_q.push_back(mk(1, 32'h9999, 7));
        tick(0);

        // Load-use on rt: one bubble, then MEM forwards the loaded value.
        idle();
        id_valid = 1; id_rs = 1; id_rt = 3; id_use_rs = 1; id_use_rt = 1; id_pc = 32'h80;
        ex_valid = 1; ex_regwr = 1; ex_memrd = 1; ex_wr_reg = 3; ex_result = 32'hDEAD;
        exp_q.push_back(mk(0, 0, 0));
        tick(1);
        ex_valid = 0; ex_regwr = 0; ex_memrd = 0; ex_wr_reg = 0;
        mem_valid = 1; mem_regwr = 1; mem_wr_reg = 3; mem_result = 32'hBEEF;
        exp_q.push_back(mk(1, 7, 32'hBEEF));
        tick(0);

        // Branch resolution on forwarded operands.
        idle();
        id_valid = 1; id_rs = 1; id_rt = 2; id_pc = 32'h100; id_imm16 = 16'hFFFE;
        br_chk("beq_taken", 3'd2, 1);
        chk("br_target", br_target, 32'h0000_00FC);
        br_chk("bne_eq", 3'd3, 0);
        br_chk("bgtz_pos", 3'd5, 1);
        br_chk("bltz_pos", 3'd1, 0);
        br_chk("reserved", 3'd7, 0);
        id_rs = 4;
        br_chk("bltz_neg", 3'd1, 1);
        br_chk("blez_neg", 3'd4, 1);
        br_chk("bgez_neg", 3'd6, 0);
        id_rs = 0;
        br_chk("blez_zero", 3'd4, 1);
        id_imm16 = 16'h0010; id_pc = 32'h200;
        #1;
        chk("br_target_fwd", br_target, 32'h0000_0244);
        wb_write(2, 8);
        id_valid = 1; id_rs = 1; id_rt = 2; id_pc = 32'h100; id_imm16 = 16'hFFFE;
        br_chk("beq_not_taken", 3'd2, 0);
        br_chk("bne_taken", 3'd3, 1);
        exp_q.push_back(mk(1, 7, 8));
        tick(0);

        // Flush overrides a taken branch and a load-use hazard.
        idle();
        id_valid = 1; id_rs = 1; id_rt = 1; id_use_rs = 1; id_br_type = 3'd2;
        ex_valid = 1; ex_regwr = 1; ex_memrd = 1; ex_wr_reg = 1; ex_flush = 1;
        #1;
        chk("flush_br_taken", XLEN'(br_taken), 0);
        exp_q.push_back(mk(0, 0, 0));
        tick(0);

        // WB to the register being read.
        idle();
        id_valid = 1; id_rs = 9; id_use_rs = 1; id_pc = 32'h300;
        wb_regwr = 1; wb_wr_reg = 9; wb_data = 32'hAA;
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(mk(1, 32'hAA, 0));
        tick(0);
`else
        exp_q.push_back(mk(0, 0, 0));
        tick(1);
        wb_regwr = 0; wb_wr_reg = 0; wb_data = 0;
        exp_q.push_back(mk(1, 32'hAA, 0));
        tick(0);
`endif

        // Register 0 ignores writes and is never forwarded.
        wb_write(0, 32'h77);
        id_valid = 1; id_rs = 0; id_rt = 5; id_use_rs = 1; id_use_rt = 1; id_pc = 32'h400;
        ex_valid = 1; ex_regwr = 1; ex_wr_reg = 0; ex_result = 32'h1111;
        mem_valid = 1; mem_regwr = 1; mem_wr_reg = 0; mem_result = 32'h2222;
        exp_q.push_back(mk(1, 0, 32'h55));
        tick(0);

        // Held load-use stall drives the counter to saturation.
        idle();
        id_valid = 1; id_rs = 3; id_use_rs = 1;
        ex_valid = 1; ex_regwr = 1; ex_memrd = 1; ex_wr_reg = 3;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(mk(0, 0, 0));
            tick(1);
        end
        chk("count_saturated", XLEN'(stall_count), XLEN'({CNT_W{1'b1}}));

        // Asynchronous reset in the middle of a stall.
        #2;
        reset = 0;
        exp_cnt = '0;
        #1;
        chk("midrst_idex_valid",  XLEN'(idex_valid),  0);
        chk("midrst_idex_pc",     idex_pc,            0);
        chk("midrst_idex_ctrl",   XLEN'(idex_ctrl),   0);
        chk("midrst_stall_count", XLEN'(stall_count), 0);
        idle();
        @(posedge clk); #1;
        reset = 1;
        id_valid = 1; id_rs = 1; id_rt = 5; id_use_rs = 1; id_pc = 32'h500;
        exp_q.push_back(mk(1, 0, 0));
        tick(0);

        chk("scoreboard_drained", XLEN'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
